ifetch_ctrl: RTL
================

# ifetch_ctrl

Instruction-fetch controller between the PC register and the IF/ID pipeline boundary. It issues the current PC to the instruction cache and raises the cache-stall line back to the PC and the pipeline while a fetch is outstanding. It owns the IF/ID latch (PC+4, instruction, valid) and honours hazard stall and branch flush, including flushes that arrive during a miss. Downstream decode reads only the latched IF/ID outputs.

## Interface
- No parameters; all widths are fixed at 32 bits.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  CPU run enable; low forces IDLE and clears IF/ID.
- pc_i  in  32  current fetch address from the PC register.
- stall_i  in  1  load-use hazard stall; IF/ID holds.
- flush_i  in  1  taken branch/jump; IF/ID becomes a bubble.
- mem_ack_i  in  1  cache returns data this cycle; a hit acks in the request cycle.
- mem_data_i  in  32  instruction word, valid when mem_ack_i=1.
- mem_req_o  out  1  fetch request.
- mem_addr_o  out  32  fetch address, equal to pc_i.
- fetch_stall_o  out  1  drives the PC and pipeline CacheStall.
- if_id_pc4_o  out  32  latched PC+4.
- if_id_inst_o  out  32  latched instruction; 0 (NOP) when bubble.
- if_id_valid_o  out  1  latched instruction is real.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. Encoding is 2 bits.
- IDLE:
  - mem_req_o=0, fetch_stall_o=0, IF/ID cleared.
  - start_i=1 goes to FETCH.
- FETCH:
  - mem_req_o=1, mem_addr_o=pc_i, fetch_stall_o=~mem_ack_i.
  - ack & flush_i: IF/ID loads a bubble (pc4=0, inst=0, valid=0). Stay in FETCH.
  - ack & ~flush_i & ~stall_i: IF/ID loads {pc_i+4, mem_data_i, 1}. Stay in FETCH.
  - ack & ~flush_i & stall_i: capture mem_data_i and pc_i+4 into the hold buffer; IF/ID unchanged. Go to HOLD.
  - ~ack & flush_i: go to DRAIN, because an in-flight request cannot be cancelled.
  - ~ack otherwise: stay in FETCH with IF/ID unchanged.
- HOLD:
  - mem_req_o=0, fetch_stall_o=0. The PC is held by stall_i.
  - flush_i: IF/ID loads a bubble and the buffer is discarded. Go to FETCH.
  - Else ~stall_i: IF/ID loads the buffer with valid=1. Go to FETCH.
  - Else: stay in HOLD.
- DRAIN:
  - mem_req_o=1, mem_addr_o=pc_i, fetch_stall_o=~mem_ack_i.
  - On ack the data is dropped and IF/ID loads a bubble. Go to FETCH.
- Priority: rst_i > ~start_i > flush_i > stall_i.
- PC+4 is computed modulo 2^32, so 0xFFFFFFFC+4 = 0.

## Timing
- Reset and ~start_i values: state=IDLE; every output 0; hold buffer 0.
- Entering FETCH from IDLE costs 1 cycle; the first request is on the cycle after start_i rises.
- Hit: IF/ID is valid on the edge that ends the request cycle, so latency is 1 cycle and throughput is one instruction per cycle.
- Miss of N cycles: fetch_stall_o is high for exactly N cycles and IF/ID loads on the ack edge.
- mem_addr_o stays stable for the whole miss, since the PC is frozen by fetch_stall_o.
- Reset or start_i falling mid-miss: go to IDLE immediately. A later stray ack is ignored outside FETCH/DRAIN.

## Configuration
- IFETCH_PERF_EN defined: adds outputs perf_fetch_o (32) and perf_miss_cyc_o (32).
  - perf_fetch_o counts IF/ID loads with valid=1.
  - perf_miss_cyc_o counts cycles with fetch_stall_o=1.
  - Both saturate at 0xFFFFFFFF and clear on rst_i.
- IFETCH_PERF_EN undefined: neither port nor counter logic exists; all other behaviour is identical.

## Structure
- Shared package ifetch_pkg holds:
  - the state enum (IDLE/FETCH/HOLD/DRAIN);
  - NOP_INST=32'h0;
  - PC_STEP=32'd4.
- Optional sub-module ifetch_perf holds the two saturating counters. It is instantiated only under IFETCH_PERF_EN.
- The IF/ID latch and hold buffer stay inline.

## Test plan
- Hits: start_i=1, pc_i=0x00, 0x04, 0x08, with ack in the request cycle each time and mem_data_i=0x20080005, … → IF/ID shows pc4=0x04 with 0x20080005, then 0x08, then 0x0C, valid=1 on consecutive cycles, and fetch_stall_o is never high.
- Miss: pc_i=0x40, ack after 3 cycles with data 0x8C090000 → fetch_stall_o is high for 3 cycles, mem_addr_o=0x40 throughout, then IF/ID={0x44, 0x8C090000, 1}.
- Hit under stall_i: stall_i held for 2 cycles → HOLD, IF/ID unchanged. When stall_i drops, IF/ID loads the buffered word and mem_req_o=0 during HOLD.
- Flush during miss: flush_i pulsed in miss cycle 1, ack in cycle 4 → DRAIN, and on ack IF/ID={0, 0, 0} with fetch_stall_o dropping on the ack cycle.
- Flush and stall together on a hit: IF/ID loads a bubble, so flush wins.
- Reset mid-miss: rst_i=1 on miss cycle 2 → next cycle all outputs 0 and state is IDLE. A later ack has no effect, and with IFETCH_PERF_EN both counters read 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the FSM state type and the NOP / PC increment values.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/ifetch_perf.sv
// Saturating event counters for fetch performance: delivered instructions and miss-stall cycles.
// Latency: counts visible one cycle after the event; no backpressure; cleared only by rst_i.
module ifetch_perf
    import ifetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_fetch_inc,
    input  logic        i_miss_inc,
    output logic [31:0] o_perf_fetch,
    output logic [31:0] o_perf_miss_cyc
);

    logic [31:0] r_fetch;
    logic [31:0] r_miss;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch <= '0;
            r_miss  <= '0;
        end else begin
            if (i_fetch_inc && (r_fetch != 32'hFFFF_FFFF)) r_fetch <= r_fetch + 32'd1;
            if (i_miss_inc  && (r_miss  != 32'hFFFF_FFFF)) r_miss  <= r_miss  + 32'd1;
        end
    end

    assign o_perf_fetch    = r_fetch;
    assign o_perf_miss_cyc = r_miss;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: issues pc_i to the I-cache, stalls the PC on a miss, owns the IF/ID latch.
// Latency 1 cycle on a hit; stall_i parks a fetched word in a hold buffer; IFETCH_PERF_EN adds perf counters.
module ifetch_ctrl
    import ifetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        fetch_stall_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_inst_o,
    output logic        if_id_valid_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_miss_cyc_o
`endif
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_pc4;
    logic [31:0] r_inst;
    logic        r_valid;
    logic [31:0] r_hold_pc4;
    logic [31:0] r_hold_inst;

    logic        w_run;
    logic        w_req;
    logic        w_ack;
    logic [31:0] w_pc4;
    logic        w_load;
    logic [31:0] w_load_pc4;
    logic [31:0] w_load_inst;
    logic        w_load_valid;
    logic        w_capture;
    logic        w_hold_clr;

    // Reset and a dropped start_i silence the cache port in the same cycle.
    assign w_run = start_i & ~rst_i;
    assign w_req = w_run & ((r_state == ST_FETCH) || (r_state == ST_DRAIN));
    assign w_ack = w_req & mem_ack_i;
    assign w_pc4 = pc_i + PC_STEP;

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_pc4   = '0;
        w_load_inst  = NOP_INST;
        w_load_valid = 1'b0;
        w_capture    = 1'b0;
        w_hold_clr   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_ack) begin
                    if (flush_i) begin
                        w_load = 1'b1;
                    end else if (!stall_i) begin
                        w_load       = 1'b1;
                        w_load_pc4   = w_pc4;
                        w_load_inst  = mem_data_i;
                        w_load_valid = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (flush_i) begin
                    // The request already in flight cannot be recalled; wait for its ack.
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    w_load      = 1'b1;
                    w_hold_clr  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else if (!stall_i) begin
                    w_load       = 1'b1;
                    w_load_pc4   = r_hold_pc4;
                    w_load_inst  = r_hold_inst;
                    w_load_valid = 1'b1;
                    w_hold_clr   = 1'b1;
                    w_state_nxt  = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (w_ack) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !start_i) begin
            r_state     <= ST_IDLE;
            r_pc4       <= '0;
            r_inst      <= NOP_INST;
            r_valid     <= 1'b0;
            r_hold_pc4  <= '0;
            r_hold_inst <= NOP_INST;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_pc4   <= w_load_pc4;
                r_inst  <= w_load_inst;
                r_valid <= w_load_valid;
            end
            if (w_capture) begin
                r_hold_pc4  <= w_pc4;
                r_hold_inst <= mem_data_i;
            end else if (w_hold_clr) begin
                r_hold_pc4  <= '0;
                r_hold_inst <= NOP_INST;
            end
        end
    end

    assign mem_req_o     = w_req;
    assign mem_addr_o    = w_req ? pc_i : 32'h0;
    assign fetch_stall_o = w_req & ~mem_ack_i;
    assign if_id_pc4_o   = r_pc4;
    assign if_id_inst_o  = r_inst;
    assign if_id_valid_o = r_valid;

`ifdef IFETCH_PERF_EN
    ifetch_perf u_perf (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .i_fetch_inc     (w_run & w_load & w_load_valid),
        .i_miss_inc      (fetch_stall_o),
        .o_perf_fetch    (perf_fetch_o),
        .o_perf_miss_cyc (perf_miss_cyc_o)
    );
`endif

endmodule
